// File: rtl/iter_alu.sv
// iter_alu: multi-cycle integer ALU (add/sub single cycle, mul/div one bit
// per clock) with registered valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (op, is_signed, a, b)
//   out_valid/out_ready  result handshake (result, remainder, flags)
//   result               sum / diff / low product half / quotient
//   remainder            division remainder, 0 for other ops
//   carry                add carry-out, sub borrow, else 0
//   ovf                  overflow for the current op and signedness
//   div_zero             division with b == 0
module iter_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;

    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             sgn;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mag_b;

    assign in_ready = (state == IDLE) & rst_n;

    // Add/sub path evaluated straight from the inputs at acceptance.
    logic             sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] as_res;
    logic             as_carry;
    logic             as_sovf;
    logic             as_ovf;

    assign sub      = op[0];
    assign b_x      = sub ? ~b : b;
    assign sum_w    = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    assign as_res   = sum_w[WIDTH-1:0];
    // For sub the adder carry is the inverse of the borrow.
    assign as_carry = sub ? ~sum_w[WIDTH] : sum_w[WIDTH];
    assign as_sovf  = (sub ? (a[WIDTH-1] != b[WIDTH-1])
                           : (a[WIDTH-1] == b[WIDTH-1]))
                    & (as_res[WIDTH-1] != a[WIDTH-1]);
    assign as_ovf   = is_signed ? as_sovf : as_carry;

    // Operand magnitudes for the iterative engines.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             is_addsub;
    logic             div_by_zero;

    assign a_neg       = is_signed & a[WIDTH-1];
    assign b_neg       = is_signed & b[WIDTH-1];
    assign mag_a_in    = a_neg ? (~a + ONE) : a;
    assign mag_b_in    = b_neg ? (~b + ONE) : b;
    assign is_addsub   = ~op[1];
    assign div_by_zero = (op == OP_DIV) & ~(|b);

    // Shift-add multiply step: acc_hi accumulates, acc_lo holds the
    // multiplier and collects product low bits as it shifts right.
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign mul_add = acc_lo[0] ? mag_b : '0;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Restoring divide step: acc_hi is the partial remainder, acc_lo
    // shifts the dividend out and the quotient in. The extra top bit of
    // the trial difference covers a shifted remainder of up to WIDTH+1 bits.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_fit;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    assign div_fit   = ~div_diff[WIDTH+1];
    assign div_hi    = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo    = {acc_lo[WIDTH-2:0], div_fit};

    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign nxt_hi = is_div ? div_hi : mul_hi;
    assign nxt_lo = is_div ? div_lo : mul_lo;

    // Sign fix applied to the values produced by the last iteration.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic               div_ovf;

    assign prod     = {nxt_hi, nxt_lo};
    assign prod_s   = neg_q ? (~prod + ONE2) : prod;
    assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = sgn ? ~((&prod_top) | ~(|prod_top))
                          : |prod_s[2*WIDTH-1:WIDTH];
    assign q_s      = neg_q ? (~nxt_lo + ONE) : nxt_lo;
    assign r_s      = neg_r ? (~nxt_hi + ONE) : nxt_hi;
    // A non-negated signed quotient with its MSB set can only be MIN/-1.
    assign div_ovf  = sgn & ~neg_q & nxt_lo[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            sgn       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mag_b     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            remainder <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_div <= op[0];
                        sgn    <= is_signed;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        unique case (1'b1)
                            is_addsub: begin
                                result    <= as_res;
                                remainder <= '0;
                                carry     <= as_carry;
                                ovf       <= as_ovf;
                                div_zero  <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            div_by_zero: begin
                                result    <= '1;
                                remainder <= a;
                                carry     <= 1'b0;
                                ovf       <= 1'b0;
                                div_zero  <= 1'b1;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            default: begin
                                acc_hi <= '0;
                                acc_lo <= mag_a_in;
                                mag_b  <= mag_b_in;
                                cnt    <= CNT_W'(WIDTH);
                                state  <= CALC;
                            end
                        endcase
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        carry     <= 1'b0;
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        if (is_div) begin
                            result    <= q_s;
                            remainder <= r_s;
                            ovf       <= div_ovf;
                        end else begin
                            result    <= prod_s[WIDTH-1:0];
                            remainder <= '0;
                            ovf       <= mul_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vectors for iter_alu (WIDTH=16) with a queue-based
// scoreboard checked by an independent output monitor.
module tb_iter_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         carry;
    logic         ovf;
    logic         div_zero;

    typedef struct {
        string        nm;
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         c;
        logic         o;
        logic         z;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;

    iter_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .remainder (remainder),
        .carry     (carry),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare once per presented result.
    always @(negedge clk) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none",
                         result);
            end else begin
                e = sb.pop_front();
                check({e.nm, "_result"}, 32'(result), 32'(e.res));
                check({e.nm, "_rem"}, 32'(remainder), 32'(e.rem));
                check({e.nm, "_carry"}, 32'(carry), 32'(e.c));
                check({e.nm, "_ovf"}, 32'(ovf), 32'(e.o));
                check({e.nm, "_dz"}, 32'(div_zero), 32'(e.z));
                check({e.nm, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    // lat counts the accept cycle as clock 1.
    task automatic issue(input string nm, input logic [1:0] o,
                         input logic s, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input logic [W-1:0] xr,
                         input logic [W-1:0] xm, input logic xc,
                         input logic xo, input logic xz, input int lat,
                         input bit wait_done);
        int   k;
        exp_t t;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got 0 expected 1", nm);
            return;
        end
        in_valid  = 1'b1;
        op        = o;
        is_signed = s;
        a         = xa;
        b         = xb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        t.nm  = nm;
        t.res = xr;
        t.rem = xm;
        t.c   = xc;
        t.o   = xo;
        t.z   = xz;
        t.due = cyc + lat - 1;
        sb.push_back(t);
        if (wait_done) begin
            k = 0;
            @(negedge clk);
            while ((out_valid || sb.size() != 0) && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (out_valid || sb.size() != 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_done_timeout: got pending expected idle",
                         nm);
                sb.delete();
            end
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_result"}, 32'(result), 32'd0);
        check({nm, "_rem"}, 32'(remainder), 32'd0);
        check({nm, "_flags"}, {29'd0, carry, ovf, div_zero}, 32'd0);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_in_ready", 32'(in_ready), 32'd1);

        //     name       op     s     a         b         result    rem
        issue("add_u",    2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000,
              1'b1, 1'b1, 1'b0, 1, 1'b1);
        issue("add_s",    2'b00, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000,
              1'b0, 1'b1, 1'b0, 1, 1'b1);
        issue("sub_s",    2'b01, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000,
              1'b1, 1'b0, 1'b0, 1, 1'b1);
        issue("sub_u",    2'b01, 1'b0, 16'h0007, 16'h0005, 16'h0002, 16'h0000,
              1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("sub_s_min",2'b01, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000,
              1'b0, 1'b1, 1'b0, 1, 1'b1);
        issue("mul_s",    2'b10, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 16'h0000,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("mul_u_ovf",2'b10, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000,
              1'b0, 1'b1, 1'b0, 17, 1'b1);
        issue("mul_s_ovf",2'b10, 1'b1, 16'h4000, 16'h0002, 16'h8000, 16'h0000,
              1'b0, 1'b1, 1'b0, 17, 1'b1);
        issue("mul_u",    2'b10, 1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 16'h0000,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("mul_minsq",2'b10, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h0000,
              1'b0, 1'b1, 1'b0, 17, 1'b1);
        issue("div_s",    2'b11, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("div_s_nb", 2'b11, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("div_min",  2'b11, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000,
              1'b0, 1'b1, 1'b0, 17, 1'b1);
        issue("div_zero", 2'b11, 1'b0, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064,
              1'b0, 1'b0, 1'b1, 1, 1'b1);
        issue("div_zero_s",2'b11,1'b1, 16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB,
              1'b0, 1'b0, 1'b1, 1, 1'b1);
        issue("div_u",    2'b11, 1'b0, 16'h03E8, 16'h0007, 16'h008E, 16'h0006,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("div_u_big",2'b11, 1'b0, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE,
              1'b0, 1'b0, 1'b0, 17, 1'b1);
        issue("div_u_3",  2'b11, 1'b0, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000,
              1'b0, 1'b0, 1'b0, 17, 1'b1);

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        issue("bp_add",   2'b00, 1'b0, 16'h1234, 16'h1111, 16'h2345, 16'h0000,
              1'b0, 1'b0, 1'b0, 1, 1'b0);
        in_valid  = 1'b1;
        op        = 2'b10;
        a         = 16'h0003;
        b         = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(result), 32'h2345);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset during the multiply iterations.
        issue("rst_mul",  2'b10, 1'b0, 16'h1234, 16'h0056, 16'h0000, 16'h0000,
              1'b0, 1'b0, 1'b0, 17, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        issue("post_rst", 2'b00, 1'b0, 16'h0010, 16'h0020, 16'h0030, 16'h0000,
              1'b0, 1'b0, 1'b0, 1, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
